// File: rtl/seg_disp_arbiter_pkg.sv
// Shared definitions for the 6-digit 7-segment display arbiter:
// digit count, scan FSM states, display owner encoding and the
// active-high segment patterns ([0]=a .. [6]=g).
package seg_disp_arbiter_pkg;

  localparam int unsigned NUM_DIG = 6;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_SRC0 = 2'd1,
    OWN_SRC1 = 2'd2
  } owner_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder.
//   i_bcd : 4-bit digit code; 10-15 decode to blank
//   o_seg : active-high segments, [0]=a .. [6]=g
module bcd_to_seg7
  import seg_disp_arbiter_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Shares a 6-digit multiplexed 7-segment display between a normal source
// (src0) and a priority source (src1). Ownership changes only at frame
// boundaries; each digit advance is followed by BLANK_CYC cycles with all
// digit enables low to suppress ghosting.
//   clk, rst          : clock, synchronous active-high reset
//   i_scan_tick       : one-cycle pulse, advances one digit
//   i_req0/i_bcd0/i_dp0 : src0 request, digits ([3:0] = digit 0), dp mask
//   i_req1/i_bcd1/i_dp1 : src1 (priority) request, digits, dp mask
//   o_gnt0/o_gnt1     : current owner
//   o_seg_enb         : one-hot digit enable
//   o_seg_dp, o_seg   : decimal point and segments of the active digit
module seg_disp_arbiter
  import seg_disp_arbiter_pkg::*;
#(
  parameter int unsigned BLANK_CYC   = 4,
  parameter int unsigned HOLD_FRAMES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_scan_tick,
  input  logic                   i_req0,
  input  logic [4*NUM_DIG-1:0]   i_bcd0,
  input  logic [NUM_DIG-1:0]     i_dp0,
  input  logic                   i_req1,
  input  logic [4*NUM_DIG-1:0]   i_bcd1,
  input  logic [NUM_DIG-1:0]     i_dp1,
  output logic                   o_gnt0,
  output logic                   o_gnt1,
  output logic [NUM_DIG-1:0]     o_seg_enb,
  output logic                   o_seg_dp,
  output logic [6:0]             o_seg
);

  localparam logic [2:0]  LAST_DIG = 3'(NUM_DIG - 1);
  localparam int unsigned BW       = (BLANK_CYC < 2) ? 1 : $clog2(BLANK_CYC + 1);
  localparam int unsigned HW       = (HOLD_FRAMES < 3) ? 1 : $clog2(HOLD_FRAMES);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYC);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);

  state_e                 st_q, st_d;
  owner_e                 own_q, own_d;
  logic [2:0]             dig_q, dig_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [BW-1:0]          blank_q, blank_d;
  logic [4*NUM_DIG-1:0]   snap_bcd_q, snap_bcd_d;
  logic [NUM_DIG-1:0]     snap_dp_q, snap_dp_d;

  logic [NUM_DIG-1:0]     seg_enb_q, seg_enb_d;
  logic [6:0]             seg_q, seg_d;
  logic                   seg_dp_q, seg_dp_d;
  logic                   gnt0_q, gnt0_d;
  logic                   gnt1_q, gnt1_d;

  logic [3:0]             nibble_d;
  logic [6:0]             dec_seg;

  always_comb begin
    st_d       = st_q;
    own_d      = own_q;
    dig_d      = dig_q;
    hold_d     = hold_q;
    blank_d    = blank_q;
    snap_bcd_d = snap_bcd_q;
    snap_dp_d  = snap_dp_q;

    if (i_scan_tick) begin
      dig_d = (dig_q == LAST_DIG) ? '0 : dig_q + 3'd1;

      if (dig_q == LAST_DIG) begin
        if ((own_q == OWN_SRC1) && (hold_q != '0)) begin
          own_d  = OWN_SRC1;
          hold_d = hold_q - HW'(1);
        end else if (i_req1) begin
          own_d = OWN_SRC1;
          if (own_q != OWN_SRC1) begin
            hold_d = HOLD_LOAD;
          end
        end else if (i_req0) begin
          own_d = OWN_SRC0;
        end else begin
          own_d = OWN_NONE;
        end

        case (own_d)
          OWN_SRC0: begin
            snap_bcd_d = i_bcd0;
            snap_dp_d  = i_dp0;
          end
          OWN_SRC1: begin
            snap_bcd_d = i_bcd1;
            snap_dp_d  = i_dp1;
          end
          default: begin
            snap_bcd_d = '0;
            snap_dp_d  = '0;
          end
        endcase
      end

      // With no owner a tick only moves the digit index; the display stays dark.
      if (own_d == OWN_NONE) begin
        st_d    = ST_OFF;
        blank_d = '0;
      end else if (BLANK_CYC > 0) begin
        st_d    = ST_BLANK;
        blank_d = BLANK_LOAD;
      end else begin
        st_d = ST_ON;
      end
    end else if (st_q == ST_BLANK) begin
      if (blank_q <= BW'(1)) begin
        st_d    = ST_ON;
        blank_d = '0;
      end else begin
        blank_d = blank_q - BW'(1);
      end
    end
  end

  // Output registers are loaded from the next-state view so that the grant,
  // the digit enable and its segments all change on the same edge.
  assign nibble_d = snap_bcd_d[{dig_d, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .i_bcd (nibble_d),
    .o_seg (dec_seg)
  );

  always_comb begin
    seg_enb_d = '0;
    seg_d     = '0;
    seg_dp_d  = 1'b0;
    if (st_d == ST_ON) begin
      seg_enb_d = NUM_DIG'(1) << dig_d;
      seg_d     = dec_seg;
      seg_dp_d  = snap_dp_d[dig_d];
    end
    gnt0_d = (own_d == OWN_SRC0);
    gnt1_d = (own_d == OWN_SRC1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_OFF;
      own_q      <= OWN_NONE;
      dig_q      <= LAST_DIG;
      hold_q     <= '0;
      blank_q    <= '0;
      snap_bcd_q <= '0;
      snap_dp_q  <= '0;
      seg_enb_q  <= '0;
      seg_q      <= '0;
      seg_dp_q   <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      own_q      <= own_d;
      dig_q      <= dig_d;
      hold_q     <= hold_d;
      blank_q    <= blank_d;
      snap_bcd_q <= snap_bcd_d;
      snap_dp_q  <= snap_dp_d;
      seg_enb_q  <= seg_enb_d;
      seg_q      <= seg_d;
      seg_dp_q   <= seg_dp_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
    end
  end

  assign o_gnt0    = gnt0_q;
  assign o_gnt1    = gnt1_q;
  assign o_seg_enb = seg_enb_q;
  assign o_seg_dp  = seg_dp_q;
  assign o_seg     = seg_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
module tb_seg_disp_arbiter;

  localparam int BLANK_CYC   = 4;
  localparam int HOLD_FRAMES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_scan_tick = 1'b0;
  logic        i_req0 = 1'b0;
  logic [23:0] i_bcd0 = '0;
  logic [5:0]  i_dp0 = '0;
  logic        i_req1 = 1'b0;
  logic [23:0] i_bcd1 = '0;
  logic [5:0]  i_dp1 = '0;
  logic        o_gnt0, o_gnt1, o_seg_dp;
  logic [5:0]  o_seg_enb;
  logic [6:0]  o_seg;

  int total = 0;
  int bad   = 0;

  // Reference view of the display: who owns it, which digit is addressed,
  // how many dark cycles remain, and the frame's latched digit codes.
  int m_dig, m_own, m_hold, m_dark;
  int m_code [6];
  bit m_dp   [6];
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  seg_disp_arbiter #(.BLANK_CYC(BLANK_CYC), .HOLD_FRAMES(HOLD_FRAMES)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_scan_tick (i_scan_tick),
    .i_req0      (i_req0),
    .i_bcd0      (i_bcd0),
    .i_dp0       (i_dp0),
    .i_req1      (i_req1),
    .i_bcd1      (i_bcd1),
    .i_dp1       (i_dp1),
    .o_gnt0      (o_gnt0),
    .o_gnt1      (o_gnt1),
    .o_seg_enb   (o_seg_enb),
    .o_seg_dp    (o_seg_dp),
    .o_seg       (o_seg)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit boundary;
    if (rst) begin
      m_dig = 5; m_own = 0; m_hold = 0; m_dark = 0;
    end else if (i_scan_tick) begin
      boundary = (m_dig == 5);
      m_dig = (m_dig + 1) % 6;
      if (boundary) begin
        if (m_own == 2 && m_hold > 0) m_hold--;
        else if (i_req1) begin
          if (m_own != 2) m_hold = HOLD_FRAMES - 1;
          m_own = 2;
        end else if (i_req0) m_own = 1;
        else m_own = 0;
        for (int k = 0; k < 6; k++) begin
          m_code[k] = (m_own == 2) ? int'(i_bcd1[4*k +: 4]) : (m_own == 1) ? int'(i_bcd0[4*k +: 4]) : 0;
          m_dp[k]   = (m_own == 2) ? i_dp1[k] : (m_own == 1) ? i_dp0[k] : 1'b0;
        end
      end
      m_dark = (m_own == 0) ? 0 : BLANK_CYC;
    end else if (m_dark > 0) begin
      m_dark--;
    end
  endtask

  task automatic check_all();
    bit shown;
    shown = (m_own != 0) && (m_dark == 0);
    chk("seg_enb", 32'(o_seg_enb), shown ? 32'(1 << m_dig) : 32'd0);
    chk("seg",     32'(o_seg),     shown ? 32'(seg_tab[m_code[m_dig]]) : 32'd0);
    chk("seg_dp",  32'(o_seg_dp),  shown ? 32'(m_dp[m_dig]) : 32'd0);
    chk("gnt0",    32'(o_gnt0),    32'(m_own == 1));
    chk("gnt1",    32'(o_gnt1),    32'(m_own == 2));
    chk("enb_onehot0", 32'($countones(o_seg_enb) <= 1), 32'd1);
    chk("gnt_excl",    32'(o_gnt0 & o_gnt1), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic tick_step();
    i_scan_tick = 1'b1;
    step();
    i_scan_tick = 1'b0;
    chk("tick_blank", 32'(o_seg_enb), 32'd0);
  endtask

  // Remainder of a digit slot after its tick: 3 more dark cycles, the lit
  // cycle, then idle up to a 10-cycle slot.
  task automatic finish_digit(input int k, input logic [6:0] exp_seg);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("blank_hold", 32'(o_seg_enb), 32'd0);
    end
    step();
    chk("digit_enb", 32'(o_seg_enb), 32'(1 << k));
    chk("digit_seg", 32'(o_seg), 32'(exp_seg));
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic do_digit(input int k, input logic [6:0] exp_seg);
    tick_step();
    finish_digit(k, exp_seg);
  endtask

  initial begin
    // Reset then idle
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int t = 0; t < 12; t++) begin
      i_scan_tick = 1'b1;
      step();
      i_scan_tick = 1'b0;
      for (int i = 0; i < 3; i++) step();
    end
    chk("idle_gnt0", 32'(o_gnt0), 32'd0);
    chk("idle_gnt1", 32'(o_gnt1), 32'd0);

    // Single source
    i_req0 = 1'b1; i_bcd0 = 24'h543210; i_dp0 = 6'b000100;
    tick_step();
    chk("single_gnt0", 32'(o_gnt0), 32'd1);
    finish_digit(0, 7'h3F);
    for (int k = 1; k < 6; k++) begin
      tick_step();
      for (int i = 0; i < 3; i++) step();
      step();
      chk("single_enb", 32'(o_seg_enb), 32'(1 << k));
      if (k == 2) begin
        chk("single_seg2", 32'(o_seg), 32'h5B);
        chk("single_dp2", 32'(o_seg_dp), 32'd1);
      end
      for (int i = 0; i < 5; i++) step();
    end

    // Priority at a boundary: both requests raised mid-frame
    do_digit(0, 7'h3F);
    do_digit(1, 7'h06);
    i_req1 = 1'b1; i_bcd1 = 24'h888888; i_dp1 = 6'b000000;
    for (int k = 2; k < 6; k++) begin
      do_digit(k, seg_tab[k]);
      chk("prio_keep_gnt0", 32'(o_gnt0), 32'd1);
    end
    tick_step();
    chk("prio_gnt1", 32'(o_gnt1), 32'd1);
    i_req1 = 1'b0;              // hold: drop src1 one cycle after grant
    finish_digit(0, 7'h7F);
    for (int k = 1; k < 6; k++) do_digit(k, 7'h7F);
    tick_step();
    chk("hold_frame2_gnt1", 32'(o_gnt1), 32'd1);
    finish_digit(0, 7'h7F);
    for (int k = 1; k < 6; k++) do_digit(k, 7'h7F);
    tick_step();
    chk("hold_release_gnt0", 32'(o_gnt0), 32'd1);
    chk("hold_release_gnt1", 32'(o_gnt1), 32'd0);
    finish_digit(0, 7'h3F);

    // No tearing; tick during blanking restarts it
    do_digit(1, 7'h06);
    do_digit(2, 7'h5B);
    tick_step();
    for (int i = 0; i < 4; i++) step();
    chk("tear_digit3", 32'(o_seg_enb), 32'h08);
    i_bcd0 = 24'hFFFFFF;
    for (int i = 0; i < 5; i++) step();
    do_digit(4, 7'h66);
    tick_step();
    step();
    tick_step();                 // lands in ST_BLANK of digit 5
    for (int i = 0; i < 3; i++) begin
      step();
      chk("restart_blank", 32'(o_seg_enb), 32'd0);
    end
    step();
    chk("restart_enb", 32'(o_seg_enb), 32'h01);
    chk("restart_newframe_seg", 32'(o_seg), 32'h00);
    for (int i = 0; i < 5; i++) step();

    // Reset mid-frame with src1 granted
    i_bcd0 = 24'h543210;
    i_req1 = 1'b1; i_bcd1 = 24'h987654; i_dp1 = 6'b111111;
    for (int k = 1; k < 6; k++) do_digit(k, 7'h00);
    tick_step();
    chk("rstmid_gnt1", 32'(o_gnt1), 32'd1);
    finish_digit(0, 7'h66);
    do_digit(1, 7'h6D);
    tick_step();
    for (int i = 0; i < 4; i++) step();
    chk("rstmid_on2", 32'(o_seg_enb), 32'h04);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_enb", 32'(o_seg_enb), 32'd0);
    chk("rstmid_seg", 32'(o_seg), 32'd0);
    chk("rstmid_dp", 32'(o_seg_dp), 32'd0);
    chk("rstmid_gnt", 32'({o_gnt1, o_gnt0}), 32'd0);
    step();
    tick_step();
    chk("rstmid_rearb_gnt1", 32'(o_gnt1), 32'd1);

    // Random traffic against the reference model
    for (int c = 0; c < 4000; c++) begin
      i_scan_tick = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 30) == 0) i_req0 = $urandom_range(0, 1);
      if ($urandom_range(0, 30) == 0) i_req1 = $urandom_range(0, 1);
      if ($urandom_range(0, 10) == 0) begin
        i_bcd0 = 24'($urandom); i_dp0 = 6'($urandom);
        i_bcd1 = 24'($urandom); i_dp1 = 6'($urandom);
      end
      rst = ($urandom_range(0, 699) == 0);
      step();
    end
    rst = 1'b0;
    i_scan_tick = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
